// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer. One shared MAC walks each neuron's weights in turn.
// Weights and biases live in a writable bank; input and output use valid/ready handshakes.
module dense_layer_seq #(
   parameter int  DATA_WIDTH  = 12,
   parameter int  FRAC_BITS   = 9,
   parameter int  NUM_INPUTS  = 2,
   parameter int  NUM_NEURONS = 2,
   parameter int  RELU        = 1,
   localparam int NUM_WORDS   = NUM_NEURONS * (NUM_INPUTS + 1),
   localparam int ADDR_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   input  logic                              wr_en,
   input  logic [ADDR_W-1:0]                 wr_addr,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   output logic                              busy
);

   localparam int ACC_W = 2 * DATA_WIDTH + $clog2(NUM_INPUTS + 1) + 1;
   localparam int IW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

   typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;

   state_t                           state;
   logic [DATA_WIDTH-1:0]            bank [NUM_WORDS];
   logic [NUM_INPUTS*DATA_WIDTH-1:0] x_reg;
   logic signed [ACC_W-1:0]          acc;
   logic [IW-1:0]                    i_cnt;
   logic [NW-1:0]                    n_cnt;
   logic [ADDR_W-1:0]                w_ptr;

   logic signed [DATA_WIDTH-1:0]     x_cur;
   logic signed [DATA_WIDTH-1:0]     w_cur;
   logic signed [2*DATA_WIDTH-1:0]   prod;
   logic [DATA_WIDTH-1:0]            bias_first;
   logic [DATA_WIDTH-1:0]            bias_next;
   logic [ADDR_W-1:0]                next_bias_ptr;
   logic signed [ACC_W-1:0]          shifted;
   logic signed [ACC_W-1:0]          rect;
   logic [DATA_WIDTH-1:0]            sat;
   logic                             wr_hit;
   logic                             sat_pos;
   logic                             sat_neg;

   function automatic logic signed [ACC_W-1:0] bias_ext(input logic [DATA_WIDTH-1:0] b);
      logic signed [ACC_W-1:0] e;
      e = {{(ACC_W-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
      return e <<< FRAC_BITS;
   endfunction

   assign x_cur  = x_reg[i_cnt*DATA_WIDTH +: DATA_WIDTH];
   assign w_cur  = bank[w_ptr];
   assign prod   = x_cur * w_cur;
   assign wr_hit = wr_en && ({1'b0, wr_addr} < (ADDR_W+1)'(NUM_WORDS));

   // A write landing on bias[0] in the accept cycle must already be seen by the first neuron.
   assign bias_first = (wr_hit && wr_addr == ADDR_W'(NUM_INPUTS)) ? wr_data : bank[NUM_INPUTS];

   // In ACT, w_ptr sits on bias[n]; bias[n+1] is one full neuron stride further on.
   assign next_bias_ptr = w_ptr + ADDR_W'(NUM_INPUTS + 1);
   assign bias_next     = bank[next_bias_ptr];

   assign shifted = acc >>> FRAC_BITS;
   assign rect    = (RELU != 0 && shifted[ACC_W-1]) ? '0 : shifted;
   assign sat_pos = !rect[ACC_W-1] && (|rect[ACC_W-2:DATA_WIDTH-1]);
   assign sat_neg = rect[ACC_W-1] && !(&rect[ACC_W-2:DATA_WIDTH-1]);
   assign sat     = sat_pos ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                    sat_neg ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : rect[DATA_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         out_data  <= '0;
         x_reg     <= '0;
         acc       <= '0;
         i_cnt     <= '0;
         n_cnt     <= '0;
         w_ptr     <= '0;
         for (int k = 0; k < NUM_WORDS; k++) bank[k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_hit) bank[wr_addr] <= wr_data;
               if (in_valid) begin
                  x_reg    <= in_data;
                  acc      <= bias_ext(bias_first);
                  i_cnt    <= '0;
                  n_cnt    <= '0;
                  w_ptr    <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= MAC;
               end
            end
            MAC: begin
               acc   <= acc + ACC_W'(prod);
               i_cnt <= i_cnt + 1'b1;
               w_ptr <= w_ptr + 1'b1;
               if (i_cnt == IW'(NUM_INPUTS - 1)) state <= ACT;
            end
            ACT: begin
               out_data[n_cnt*DATA_WIDTH +: DATA_WIDTH] <= sat;
               if (n_cnt == NW'(NUM_NEURONS - 1)) begin
                  out_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  n_cnt <= n_cnt + 1'b1;
                  i_cnt <= '0;
                  w_ptr <= w_ptr + 1'b1;
                  acc   <= bias_ext(bias_next);
                  state <= MAC;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: a ReLU and a linear instance share all stimulus and are
// compared every cycle against a transaction-level arithmetic model.
module tb_dense_layer_seq;

   localparam int DW   = 12;
   localparam int FRAC = 9;
   localparam int NI   = 2;
   localparam int NN   = 2;
   localparam int LAT  = NN * (NI + 1);

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [NI*DW-1:0] in_data = '0;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b0;
   logic           wr_en = 1'b0;
   logic [2:0]     wr_addr = '0;
   logic [DW-1:0]  wr_data = '0;

   logic           in_ready_r, out_valid_r, busy_r;
   logic           in_ready_l, out_valid_l, busy_l;
   logic [NN*DW-1:0] out_relu, out_lin;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   dense_layer_seq #(.DATA_WIDTH(DW), .FRAC_BITS(FRAC), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .RELU(1)) dut_relu (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_r),
      .out_data(out_relu), .out_valid(out_valid_r), .out_ready(out_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy_r));

   dense_layer_seq #(.DATA_WIDTH(DW), .FRAC_BITS(FRAC), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .RELU(0)) dut_lin (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
      .out_data(out_lin), .out_valid(out_valid_l), .out_ready(out_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy_l));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic signed [DW-1:0] m_w [NN][NI+1];
   int                   m_phase = 0;     // 0 idle, 1 computing, 2 presenting result
   int                   m_elapsed = 0;
   logic [NN*DW-1:0]     m_res_r, m_res_l;
   logic [NN*DW-1:0]     exp_out_r = '0;
   logic [NN*DW-1:0]     exp_out_l = '0;

   function automatic logic [NN*DW-1:0] model_vec(input logic [NI*DW-1:0] x, input bit relu);
      logic [NN*DW-1:0]     v;
      logic signed [DW-1:0] xe;
      longint               acc, r;
      v = '0;
      for (int n = 0; n < NN; n++) begin
         acc = longint'(m_w[n][NI]) * (longint'(1) << FRAC);
         for (int i = 0; i < NI; i++) begin
            xe = x[i*DW +: DW];
            acc += longint'(xe) * longint'(m_w[n][i]);
         end
         r = acc >>> FRAC;
         if (relu && r < 0) r = 0;
         if (r > 2047) r = 2047;
         else if (r < -2048) r = -2048;
         v[n*DW +: DW] = r[DW-1:0];
      end
      return v;
   endfunction

   always @(posedge clk) begin
      int a;
      if (!rst) begin
         for (int n = 0; n < NN; n++)
            for (int k = 0; k <= NI; k++) m_w[n][k] = '0;
         m_phase   = 0;
         m_elapsed = 0;
         exp_out_r = '0;
         exp_out_l = '0;
      end else if (m_phase == 0) begin
         a = int'(wr_addr);
         if (wr_en && a < NN * (NI + 1)) m_w[a / (NI + 1)][a % (NI + 1)] = wr_data;
         if (in_valid) begin
            m_res_r   = model_vec(in_data, 1'b1);
            m_res_l   = model_vec(in_data, 1'b0);
            m_phase   = 1;
            m_elapsed = 0;
         end
      end else if (m_phase == 1) begin
         m_elapsed++;
         for (int n = 0; n < NN; n++)
            if (m_elapsed == (n + 1) * (NI + 1)) begin
               exp_out_r[n*DW +: DW] = m_res_r[n*DW +: DW];
               exp_out_l[n*DW +: DW] = m_res_l[n*DW +: DW];
            end
         if (m_elapsed == LAT) m_phase = 2;
      end else if (out_ready) begin
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_in_ready_relu",  32'(in_ready_r),  32'(m_phase == 0));
         chk("cyc_in_ready_lin",   32'(in_ready_l),  32'(m_phase == 0));
         chk("cyc_out_valid_relu", 32'(out_valid_r), 32'(m_phase == 2));
         chk("cyc_out_valid_lin",  32'(out_valid_l), 32'(m_phase == 2));
         chk("cyc_busy_relu",      32'(busy_r),      32'(m_phase != 0));
         chk("cyc_busy_lin",       32'(busy_l),      32'(m_phase != 0));
         chk("cyc_out_data_relu",  32'(out_relu),    32'(exp_out_r));
         chk("cyc_out_data_lin",   32'(out_lin),     32'(exp_out_l));
      end
   end

   // ---------------- stimulus ----------------
   task automatic wr(input int a, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = 3'(a);
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // mode: 0 plain, 1/4 write (wa,wd) during MAC, 2 reset during MAC, 3 write in the accept cycle
   task automatic xact(input logic [NI*DW-1:0] x, input int hold, input int mode,
                       input int wa, input logic [DW-1:0] wd,
                       output logic [NN*DW-1:0] res_r, output logic [NN*DW-1:0] res_l,
                       output int lat);
      int cnt;
      cnt = 0;
      res_r = '0;
      res_l = '0;
      while (!in_ready_r && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      chk("accept_ready", 32'(in_ready_r), 32'd1);
      in_data  = x;
      in_valid = 1'b1;
      if (mode == 3) begin
         wr_en = 1'b1; wr_addr = 3'(wa); wr_data = wd;
      end
      @(negedge clk);
      in_valid = 1'b0;
      wr_en    = 1'b0;
      in_data  = 24'($urandom);
      if (mode == 1 || mode == 4) begin
         wr_en = 1'b1; wr_addr = 3'(wa); wr_data = wd;
      end
      if (mode == 2) rst = 1'b0;
      @(negedge clk);
      lat   = 1;
      wr_en = 1'b0;
      if (mode == 2) begin
         rst = 1'b1;
         return;
      end
      while (!out_valid_r && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      res_r = out_relu;
      res_l = out_lin;
      repeat (hold) @(negedge clk);
      if (hold > 0) begin
         chk("bp_stable_relu", 32'(out_relu), 32'(res_r));
         chk("bp_stable_lin",  32'(out_lin),  32'(res_l));
         chk("bp_out_valid",   32'(out_valid_r), 32'd1);
         chk("bp_in_ready",    32'(in_ready_r),  32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_in_ready",  32'(in_ready_r),  32'd1);
      chk("release_out_valid", 32'(out_valid_r), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [NN*DW-1:0] rr, rl, rr0;
      int lat;

      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("reset_in_ready",  32'(in_ready_r),  32'd1);
      chk("reset_out_valid", 32'(out_valid_r), 32'd0);
      chk("reset_out_data",  32'(out_relu),    32'd0);
      chk("reset_busy",      32'(busy_r),      32'd0);
      rst = 1'b1;
      @(negedge clk);

      wr(0, 12'h200); wr(1, 12'h200); wr(2, 12'h000);
      wr(3, 12'h200); wr(4, 12'h200); wr(5, 12'hE00);

      xact(24'h200200, 0, 0, 0, '0, rr, rl, lat);
      chk("latency_basic", 32'(lat), 32'(LAT));
      chk("basic_relu", 32'(rr), 32'h200400);
      chk("basic_lin",  32'(rl), 32'h200400);

      xact(24'h000000, 0, 0, 0, '0, rr, rl, lat);
      chk("zero_relu", 32'(rr), 32'h000000);
      chk("zero_lin",  32'(rl), 32'hE00000);

      xact(24'h000200, 0, 0, 0, '0, rr, rl, lat);
      chk("half_relu", 32'(rr), 32'h000200);
      chk("half_lin",  32'(rl), 32'h000200);

      xact(24'h200200, 0, 1, 0, 12'h400, rr0, rl, lat);
      chk("busy_write_first", 32'(rr0), 32'h200400);
      xact(24'h200200, 0, 0, 0, '0, rr, rl, lat);
      chk("busy_write_ignored", 32'(rr), 32'(rr0));
      chk("busy_write_literal", 32'(rr), 32'h200400);

      wr(0, 12'h400);
      xact(24'h200200, 0, 0, 0, '0, rr, rl, lat);
      chk("idle_write_applied", 32'(rr), 32'h200600);

      xact(24'h200200, 0, 3, 2, 12'hE00, rr, rl, lat);
      chk("write_with_accept", 32'(rr), 32'h200400);

      wr(0, 12'h600); wr(1, 12'h600); wr(2, 12'h000);
      xact(24'h600600, 10, 0, 0, '0, rr, rl, lat);
      chk("sat_pos_relu", 32'(rr), 32'h7FF7FF);
      chk("sat_pos_lin",  32'(rl), 32'h7FF7FF);

      wr(0, 12'hA00); wr(1, 12'hA00);
      xact(24'h600600, 0, 0, 0, '0, rr, rl, lat);
      chk("sat_neg_relu", 32'(rr), 32'h7FF000);
      chk("sat_neg_lin",  32'(rl), 32'h7FF800);

      xact(24'h200200, 0, 2, 0, '0, rr, rl, lat);
      chk("midreset_in_ready",  32'(in_ready_r),  32'd1);
      chk("midreset_out_valid", 32'(out_valid_r), 32'd0);
      chk("midreset_out_data",  32'(out_relu),    32'd0);
      chk("midreset_busy",      32'(busy_r),      32'd0);
      xact(24'h200200, 0, 0, 0, '0, rr, rl, lat);
      chk("after_reset_relu", 32'(rr), 32'h000000);
      chk("after_reset_lin",  32'(rl), 32'h000000);
      chk("after_reset_latency", 32'(lat), 32'(LAT));

      for (int t = 0; t < 40; t++) begin
         int mode;
         repeat ($urandom_range(0, 3)) wr($urandom_range(0, 7), 12'($urandom));
         case ($urandom_range(0, 2))
            0:       mode = 0;
            1:       mode = 3;
            default: mode = 4;
         endcase
         xact(24'($urandom), $urandom_range(0, 3), mode, $urandom_range(0, 7), 12'($urandom), rr, rl, lat);
         chk("rand_latency", 32'(lat), 32'(LAT));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
